z80_alu_addsub_seq: RTL and testbench
=====================================

Name: z80_alu_addsub_seq

Overview:
Multi-cycle, parametrised add/subtract unit for the Z80 ALU datapath. It covers 8-bit and 16-bit arithmetic (ADD/ADC/SUB/SBC/CP) with a configurable ripple slice per clock. Each operation is a start/done handshake. Flags are produced in Z80 F-register layout, with PV as true two's-complement overflow, N set for subtracts, and H taken from the nibble boundary (bit 3 for 8-bit, bit 11 for 16-bit). It sits between the register-file read ports and the F/accumulator write-back in the execution sequencer.

Parameters:
WIDTH, 8, operand width; legal values 8 or 16.
SLICE, 1, bits processed per clock; must divide WIDTH and be at most WIDTH; NSLICE = WIDTH/SLICE.

Ports:
clk  in  1  single clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request; accepted only when the block is not busy.
op  in  3  operation: ADD=0, ADC=1, SUB=2, SBC=3, CP=4; codes 5-7 are treated as ADD.
a  in  WIDTH  minuend/augend; sampled on accept.
b  in  WIDTH  subtrahend/addend; sampled on accept.
carry_in  in  1  incoming C flag; used only by ADC/SBC; sampled on accept.
busy  out  1  high while the operation is in progress.
done  out  1  one-cycle pulse when result and flags are valid.
result  out  WIDTH  sum or difference; for CP it holds the latched a.
flags  out  8  S=7, Z=6, 0=5, H=4, 0=3, PV=2, N=1, C=0.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset: state IDLE; busy=0, done=0, result=0, flags=0; slice counter and internal carry cleared. Reset during RUN abandons the operation, and no done pulse is produced.
- Accept: start=1 in IDLE or DONE. On that edge: latch a; latch b_eff = b (add) or ~b (SUB/SBC/CP); latch c0 = 0 for ADD, carry_in for ADC, 1 for SUB/CP, ~carry_in for SBC. Then state=RUN, count=0, busy=1.
- start while RUN is ignored and has no side effects.
- RUN: each edge adds slice[count] of a and b_eff plus the running carry, writes that slice into the result register, and count++. On count==NSLICE-1, next state is DONE.
- Latency: start high in cycle 0 gives done high in cycle NSLICE+1 (9 for 8/1; 5 for 16/4). busy is high from cycle 1 through cycle NSLICE.
- DONE: done=1 for exactly one cycle. result and flags then hold until the next accept or reset. A start during the DONE cycle is accepted: done=1 and the new accept occur together, and busy rises next cycle.
- Flags are computed at the transition into DONE from the full registered sum and carries:
  - S = sum[WIDTH-1].
  - Z = (sum==0).
  - H = carry out of bit (WIDTH-5) for adds, inverted for subtracts.
  - PV = carry into MSB XOR carry out of MSB.
  - N = 1 for SUB/SBC/CP, 0 otherwise.
  - C = carry out of MSB for adds, inverted (borrow) for subtracts.
  - Bits 5 and 3 = 0.
- CP: flags come from a-b; result = latched a (accumulator unchanged).
- Wrap-around: sums beyond WIDTH are truncated; the carry goes to C.

Decomposition:
- Package z80_alu_pkg:
  - op encoding constants (OP_ADD..OP_CP);
  - flag bit-index constants (FLAG_S..FLAG_C);
  - state enum.
- Sub-module z80_alu_slice:
  - combinational SLICE-bit ripple adder;
  - outputs: slice sum, carry out, and carry into the slice's top bit (needed for PV on the last slice and for H when the nibble boundary falls inside the slice).

Test Plan:
- WIDTH=8, SLICE=1, ADD a=0x7F b=0x01 -> result 0x80, flags 0x94 (S,H,PV); done in cycle 9; busy high cycles 1-8.
- WIDTH=8, SUB a=0x00 b=0x01 -> result 0xFF, flags 0x93 (S,H,N,C); ADC a=0xFF b=0x00 carry_in=1 -> 0x00, flags 0x51 (Z,H,C).
- WIDTH=8, CP a=0x80 b=0x01 -> result 0x80, flags 0x16 (H,PV,N); SBC a=0x10 b=0x0F carry_in=1 -> 0x00, flags 0x52 (Z,H,N).
- WIDTH=16, SLICE=4, ADD a=0x0FFF b=0x0001 -> 0x1000, flags 0x10 (H); done in cycle 5. ADD 0xFFFF+0x0001 -> 0x0000, flags 0x51.
- Pulse start again in cycle 3 of a RUN (8/1) with different operands -> ignored; original result is returned in cycle 9. Back-to-back start in the DONE cycle -> second done in cycle 9+9.
- Assert reset in cycle 4 of RUN -> next cycle busy=0, done=0, result=0, flags=0, and no done pulse follows. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/z80_alu_pkg.sv
// z80_alu_pkg: shared op codes, F-register bit positions and sequencer states for the Z80 add/sub unit
package z80_alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_CP  = 3'd4;
  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_H  = 4;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/z80_alu_slice.sv
// z80_alu_slice: combinational W-bit ripple adder exposing the carry into its top bit
module z80_alu_slice #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         ctop
);
  logic [W:0] c;
  always_comb begin
    c = '0;
    s = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
  assign co = c[W];
  assign ctop = c[W-1];
endmodule

// File: rtl/z80_alu_addsub_seq.sv
// z80_alu_addsub_seq: multi-cycle sliced ADD/ADC/SUB/SBC/CP with Z80 F-register flags
module z80_alu_addsub_seq
  import z80_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [7:0]       flags
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  state_t state, state_n;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_n;
  logic [CW-1:0] count;
  logic carry, is_sub, is_cp, accept, last, sub_d, c0_d, h_raw;
  logic [SLICE-1:0] a_s, b_s, s_s;
  logic co_s, ctop_s;
  logic [7:0] flags_q, flags_n;
  assign accept = start && state != S_RUN;
  assign last = count == CW'(NSLICE - 1);
  assign sub_d = op == OP_SUB || op == OP_SBC || op == OP_CP;
  assign c0_d = op == OP_ADC ? carry_in :
                (op == OP_SUB || op == OP_CP) ? 1'b1 :
                op == OP_SBC ? ~carry_in : 1'b0;
  z80_alu_slice #(.W(SLICE)) u_slice (
    .a(a_s), .b(b_s), .ci(carry), .s(s_s), .co(co_s), .ctop(ctop_s)
  );
  // Carry into bit WIDTH-4 is recovered from the full sum, so H works at any slice size
  always_comb begin
    a_s = a_q[int'(count)*SLICE +: SLICE];
    b_s = b_q[int'(count)*SLICE +: SLICE];
    sum_n = sum_q;
    sum_n[int'(count)*SLICE +: SLICE] = s_s;
    h_raw = a_q[WIDTH-4] ^ b_q[WIDTH-4] ^ sum_n[WIDTH-4];
    flags_n = '0;
    flags_n[FLAG_S] = sum_n[WIDTH-1];
    flags_n[FLAG_Z] = sum_n == '0;
    flags_n[FLAG_H] = h_raw ^ is_sub;
    flags_n[FLAG_PV] = ctop_s ^ co_s;
    flags_n[FLAG_N] = is_sub;
    flags_n[FLAG_C] = co_s ^ is_sub;
    state_n = accept ? S_RUN :
              (state == S_RUN && !last) ? S_RUN :
              state == S_RUN ? S_DONE : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      count <= '0;
      carry <= 1'b0;
      is_sub <= 1'b0;
      is_cp <= 1'b0;
      flags_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_q <= a;
        b_q <= sub_d ? ~b : b;
        carry <= c0_d;
        count <= '0;
        is_sub <= sub_d;
        is_cp <= op == OP_CP;
      end else if (state == S_RUN) begin
        sum_q <= sum_n;
        carry <= co_s;
        count <= count + 1'b1;
        if (last) flags_q <= flags_n;
      end
    end
  end
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
  assign result = is_cp ? a_q : sum_q;
  assign flags = flags_q;
endmodule

// File: tb/tb_z80_alu_addsub_seq.sv
// tb_z80_alu_addsub_seq: directed checks of the 8/1 and 16/4 add/sub sequencer
module tb_z80_alu_addsub_seq;
  logic clk = 0, reset = 1;
  logic start8 = 0, start16 = 0, cin = 0;
  logic [2:0] op = 0;
  logic [7:0] a8 = 0, b8 = 0, result8;
  logic [15:0] a16 = 0, b16 = 0, result16;
  logic busy8, done8, busy16, done16;
  logic [7:0] flags8, flags16;
  int n_asrt = 0, n_fail = 0;
  int cyc, nbusy, saw;
  always #5 clk = ~clk;
  z80_alu_addsub_seq #(.WIDTH(8), .SLICE(1)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op), .a(a8), .b(b8),
    .carry_in(cin), .busy(busy8), .done(done8), .result(result8), .flags(flags8)
  );
  z80_alu_addsub_seq #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op), .a(a16), .b(b16),
    .carry_in(cin), .busy(busy16), .done(done16), .result(result16), .flags(flags16)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input bit w, input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv, input logic ci);
    op = o;
    cin = ci;
    if (w) begin a16 = av; b16 = bv; start16 = 1; end
    else begin a8 = av[7:0]; b8 = bv[7:0]; start8 = 1; end
    tick();
    start8 = 0;
    start16 = 0;
  endtask
  task automatic wait_done(input bit w, input int c0, output int c, output int nb);
    c = c0;
    nb = 0;
    while (!(w ? done16 : done8) && c < 40) begin
      if (w ? busy16 : busy8) nb++;
      tick();
      c++;
    end
  endtask
  task automatic run(input string tag, input bit w, input logic [2:0] o, input logic [15:0] av,
                     input logic [15:0] bv, input logic ci, input logic [15:0] er, input logic [7:0] ef);
    go(w, o, av, bv, ci);
    wait_done(w, 1, cyc, nbusy);
    chk({tag, "_lat"}, cyc, w ? 5 : 9);
    chk({tag, "_busy"}, nbusy, w ? 4 : 8);
    chk({tag, "_res"}, w ? result16 : {8'h0, result8}, er);
    chk({tag, "_flg"}, w ? flags16 : flags8, ef);
  endtask
  initial begin
    tick();
    tick();
    reset = 0;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_res8", result8, 0);
    chk("rst_flg8", flags8, 0);
    chk("rst_res16", result16, 0);
    chk("rst_flg16", flags16, 0);
    run("add7f", 0, 3'd0, 16'h7F, 16'h01, 0, 16'h80, 8'h94);
    tick();
    chk("done_pulse", done8, 0);
    chk("hold_res", result8, 8'h80);
    run("sub", 0, 3'd2, 16'h00, 16'h01, 0, 16'hFF, 8'h93);
    run("adc", 0, 3'd1, 16'hFF, 16'h00, 1, 16'h00, 8'h51);
    run("cp", 0, 3'd4, 16'h80, 16'h01, 0, 16'h80, 8'h16);
    run("sbc", 0, 3'd3, 16'h10, 16'h0F, 1, 16'h00, 8'h52);
    run("op7add", 0, 3'd7, 16'h12, 16'h34, 1, 16'h46, 8'h00);
    run("add16h", 1, 3'd0, 16'h0FFF, 16'h0001, 0, 16'h1000, 8'h10);
    run("add16w", 1, 3'd0, 16'hFFFF, 16'h0001, 0, 16'h0000, 8'h51);
    run("sub16", 1, 3'd2, 16'h8000, 16'h0001, 0, 16'h7FFF, 8'h16);
    // start during RUN is ignored
    go(0, 3'd0, 16'h7F, 16'h01, 0);
    tick();
    tick();
    op = 3'd2; a8 = 8'h00; b8 = 8'h01; start8 = 1;
    tick();
    start8 = 0;
    wait_done(0, 4, cyc, nbusy);
    chk("ign_lat", cyc, 9);
    chk("ign_res", result8, 8'h80);
    chk("ign_flg", flags8, 8'h94);
    // back-to-back accept in the DONE cycle
    go(0, 3'd0, 16'h01, 16'h02, 0);
    wait_done(0, 1, cyc, nbusy);
    chk("b2b_lat1", cyc, 9);
    chk("b2b_res1", result8, 8'h03);
    go(0, 3'd2, 16'h00, 16'h01, 0);
    chk("b2b_busy", busy8, 1);
    chk("b2b_nodone", done8, 0);
    wait_done(0, 1, cyc, nbusy);
    chk("b2b_lat2", cyc + 9, 18);
    chk("b2b_res2", result8, 8'hFF);
    chk("b2b_flg2", flags8, 8'h93);
    // reset in cycle 4 of RUN
    go(0, 3'd0, 16'h7F, 16'h01, 0);
    tick();
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rr_busy", busy8, 0);
    chk("rr_done", done8, 0);
    chk("rr_res", result8, 0);
    chk("rr_flg", flags8, 0);
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) saw++;
      tick();
    end
    chk("rr_nodone", saw, 0);
    run("post_rst", 0, 3'd0, 16'h0F, 16'h01, 0, 16'h10, 8'h10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
